demux_dispatch_ctrl: RTL
========================

Name: demux_dispatch_ctrl

Overview:
- Sequencing controller for the 1:4 demultiplexer datapath.
- Accepts a single valid/ready input stream and dispatches each word to exactly one of four output channels.
- Channel selection is either round-robin or directed by a per-word select.
- Sits between a single producer and four consumer channels, with one registered holding stage.

Parameters:
- DATA_W, 8, width of the data word.
- NUM_CH, 4, number of output channels; fixed at 4, with CH_W = 2 derived.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- rst  input  1  synchronous, active-high reset.
- mode  input  1  0 = round-robin, 1 = directed; sampled only at accept.
- in_sel  input  2  target channel in directed mode; sampled at accept.
- in_valid  input  1  producer word valid.
- in_data  input  DATA_W  producer word.
- in_ready  output  1  controller can accept this cycle.
- out_valid  output  4  one-hot channel valid; bit n corresponds to channel yn.
- out_data  output  DATA_W  held word, broadcast to all channels; meaningful only where out_valid is set.
- out_ready  input  4  per-channel consumer ready.
- busy  output  1  holding register occupied (state HOLD).

Behaviour:
- Reset (rst high at a clk edge) clears state to IDLE, out_valid to 0, out_data to 0, rr_ptr to 0 and busy to 0. While rst is high, in_ready = 0.
- States:
  - IDLE: holding register empty.
  - HOLD: holding register full; tgt register is valid.
- Transfer definitions:
  - accept = in_valid & in_ready.
  - drain = busy & out_ready[tgt].
- in_ready = ~rst & (~busy | out_ready[tgt]). This is combinational and gives full throughput of one word per cycle when the target consumer is ready.
- Target on accept:
  - mode = 1: tgt = in_sel.
  - mode = 0: tgt = rr_ptr, and rr_ptr <= rr_ptr + 1 modulo 4 (3 wraps to 0).
  - Round-robin is strict: no skipping of channels that are not ready. rr_ptr does not change in directed mode.
- IDLE -> HOLD on accept: load out_data, tgt, and out_valid = one-hot(tgt).
- HOLD -> HOLD when accept and drain occur in the same cycle: the new word replaces the old one with no bubble, and the new tgt and one-hot are applied.
- HOLD -> IDLE on drain without accept: out_valid <= 0. out_data holds its last value.
- HOLD with no drain: out_data, tgt and out_valid stay stable. The word must never be dropped or changed while out_valid is set.
- out_ready on non-target channels is ignored. out_valid is never multi-hot.
- A mode or in_sel change while in HOLD affects only the next accepted word.
- Reset mid-HOLD discards the held word immediately, with no drain. rr_ptr returns to 0.
- Latency: a word is accepted at edge k and its out_valid is visible after edge k.

Optional Feature:
- Macro: DEMUX_DISPATCH_STATS_EN
- Defined:
  - Adds output stat_cnt, 4 x 8 bits (32-bit flat vector, channel n in bits [8n+7:8n]).
  - Each counter increments on each drain of its channel and saturates at 255.
  - Counters clear on rst.
  - Adds input stat_clr, 1 bit, which clears all counters synchronously. If stat_clr coincides with a drain, the clear wins.
- Undefined: these ports and counters do not exist. All other behaviour is identical.

Decomposition:
- Package demux_dispatch_pkg contains:
  - NUM_CH = 4 and CH_W = 2.
  - The state enum {IDLE, HOLD}.
  - Mode localparams MODE_RR = 0 and MODE_DIR = 1.
  - Function onehot4(ch) returning the 4-bit one-hot code.
- Sub-module demux_target_sel: combinational; takes mode, in_sel and rr_ptr, and returns tgt and next_ptr.
- The top level contains the holding register, the FSM and the optional counters.

Test Plan:
- Reset behaviour: hold rst for 2 cycles while in_valid = 1 -> in_ready = 0, out_valid = 0000, out_data = 0, busy = 0; after release, in_ready = 1.
- Round-robin streaming: mode = 0, out_ready = 1111, send 0x11, 0x22, 0x33, 0x44, 0x55 back-to-back -> out_valid = 0001, 0010, 0100, 1000, 0001 on consecutive cycles with matching data; in_ready stays 1 throughout.
- Directed backpressure: mode = 1, in_sel = 2, data 0xA5, out_ready = 1011 for 3 cycles then 1111 -> out_valid = 0100 held for 3 cycles with out_data = 0xA5; in_ready = 0 during the hold; the word drains on the 4th cycle.
- Mode switch: two round-robin words (to ch0 and ch1), then directed in_sel = 3, then a round-robin word -> targets are ch0, ch1, ch3, ch2; the directed word does not advance rr_ptr.
- Reset mid-HOLD: word 0x7E held on ch1 with out_ready = 0000, then assert rst for 1 cycle -> out_valid = 0000 and busy = 0 the next cycle; the next round-robin word goes to ch0.
- Statistics (DEMUX_DISPATCH_STATS_EN defined): drain 300 words to ch0 in directed mode -> stat_cnt for ch0 = 255, other channels = 0; pulse stat_clr -> all counters = 0.

Source files
------------

// File: rtl/demux_dispatch_ctrl_pkg.sv
// Shared types and helpers for the 1:4 demux dispatch controller.
package demux_dispatch_pkg;

    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;

    localparam logic MODE_RR  = 1'b0;
    localparam logic MODE_DIR = 1'b1;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    function automatic logic [NUM_CH-1:0] onehot4(input logic [CH_W-1:0] ch);
        logic [NUM_CH-1:0] v;
        v     = '0;
        v[ch] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/demux_dispatch_ctrl_if.sv
// Producer/consumer bundle of the dispatch controller; slave is the controller side.
interface demux_dispatch_ctrl_if #(
    parameter int DATA_W = 8
) ();
    import demux_dispatch_pkg::*;

    logic              mode;
    logic [CH_W-1:0]   in_sel;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [NUM_CH-1:0] out_valid;
    logic [DATA_W-1:0] out_data;
    logic [NUM_CH-1:0] out_ready;
    logic              busy;

    modport master (
        output mode, in_sel, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  mode, in_sel, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );

endinterface

// File: rtl/demux_dispatch_ctrl_target_sel.sv
// Combinational target pick: directed select or round-robin pointer, plus the pointer's next value.
module demux_target_sel
    import demux_dispatch_pkg::*;
(
    input  logic            i_mode,
    input  logic [CH_W-1:0] i_sel,
    input  logic [CH_W-1:0] i_rr_ptr,
    output logic [CH_W-1:0] o_tgt,
    output logic [CH_W-1:0] o_next_ptr
);

    // Pointer is CH_W bits wide, so 3 + 1 wraps to 0 on its own.
    always_comb begin
        o_tgt      = i_rr_ptr;
        o_next_ptr = i_rr_ptr + 1'b1;
        if (i_mode == MODE_DIR) begin
            o_tgt      = i_sel;
            o_next_ptr = i_rr_ptr;
        end
    end

endmodule

// File: rtl/demux_dispatch_ctrl.sv
// 1:4 dispatch controller with one holding register; word visible one edge after accept, in_ready follows the target's out_ready.
// Optional per-channel saturating drain counters under DEMUX_DISPATCH_STATS_EN.
module demux_dispatch_ctrl
    import demux_dispatch_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst,
`ifdef DEMUX_DISPATCH_STATS_EN
    input  logic                stat_clr,
    output logic [NUM_CH*8-1:0] stat_cnt,
`endif
    demux_dispatch_ctrl_if.slave bus
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_data;
    logic [CH_W-1:0]   r_tgt;
    logic [NUM_CH-1:0] r_valid;
    logic [CH_W-1:0]   r_rr_ptr;

    logic              w_busy;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_drain;
    logic [CH_W-1:0]   w_tgt;
    logic [CH_W-1:0]   w_next_ptr;

    demux_target_sel u_target_sel (
        .i_mode     (bus.mode),
        .i_sel      (bus.in_sel),
        .i_rr_ptr   (r_rr_ptr),
        .o_tgt      (w_tgt),
        .o_next_ptr (w_next_ptr)
    );

    assign w_busy     = (r_state == HOLD);
    assign w_drain    = w_busy & bus.out_ready[r_tgt];
    assign w_in_ready = ~rst & (~w_busy | bus.out_ready[r_tgt]);
    assign w_accept   = bus.in_valid & w_in_ready;

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_valid;
    assign bus.out_data  = r_data;
    assign bus.busy      = w_busy;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_nxt = HOLD;
            HOLD:    if (w_drain && !w_accept) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Accept always overrides drain so a same-cycle replacement has no bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_data   <= '0;
            r_tgt    <= '0;
            r_valid  <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_data   <= bus.in_data;
                r_tgt    <= w_tgt;
                r_valid  <= onehot4(w_tgt);
                r_rr_ptr <= w_next_ptr;
            end else if (w_drain) begin
                r_valid <= '0;
            end
        end
    end

`ifdef DEMUX_DISPATCH_STATS_EN
    logic [7:0] r_cnt [NUM_CH];

    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            for (int i = 0; i < NUM_CH; i++) r_cnt[i] <= '0;
        end else if (w_drain && r_cnt[r_tgt] != 8'hFF) begin
            r_cnt[r_tgt] <= r_cnt[r_tgt] + 8'd1;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_stat
        assign stat_cnt[8*g +: 8] = r_cnt[g];
    end
`endif

endmodule
